// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch (I) and data (D) requesters.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed D priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [3:0]  dreq_strobe,
    input  logic [31:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [31:0] dresp_data,
    output logic        mreq_valid,
    output logic [31:0] mreq_addr,
    output logic [3:0]  mreq_strobe,
    output logic [31:0] mreq_data,
    input  logic        mresp_addr_ok,
    input  logic        mresp_data_ok,
    input  logic [31:0] mresp_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       grant;
    logic       own_valid;
    logic       addr_ok;
    logic       done;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie, hand the port to whoever was not served last.
    always_comb begin
        if (ireq_valid && dreq_valid) begin
            grant = ~last_q;
        end else begin
            grant = dreq_valid ? OWN_D : OWN_I;
        end
    end

    always_comb begin
        last_d = done ? owner_q : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_D;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant = dreq_valid ? OWN_D : OWN_I;
    end
`endif

    always_comb begin
        own_valid = (owner_q == OWN_D) ? dreq_valid : ireq_valid;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_ok     = 1'b0;
        done        = 1'b0;
        mreq_valid  = 1'b0;
        mreq_addr   = 32'h0;
        mreq_strobe = 4'h0;
        mreq_data   = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (ireq_valid || dreq_valid) begin
                    owner_d = grant;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mreq_valid = own_valid;
                if (owner_q == OWN_D) begin
                    mreq_addr   = dreq_addr;
                    mreq_strobe = dreq_strobe;
                    mreq_data   = dreq_data;
                end else begin
                    mreq_addr = ireq_addr;
                end
                // A withdrawn request drops straight back to arbitration.
                if (!own_valid) begin
                    state_d = ST_IDLE;
                end else if (mresp_addr_ok) begin
                    addr_ok = 1'b1;
                    if (mresp_data_ok) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mresp_data_ok) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_D;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        iresp_addr_ok = addr_ok && (owner_q == OWN_I);
        iresp_data_ok = done && (owner_q == OWN_I);
        iresp_data    = iresp_data_ok ? mresp_data : 32'h0;
        dresp_addr_ok = addr_ok && (owner_q == OWN_D);
        dresp_data_ok = done && (owner_q == OWN_D);
        dresp_data    = dresp_data_ok ? mresp_data : 32'h0;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ireq_valid  in  1  fetch read request; ireq_addr  in  32  fetch address.
REQ-005 iresp_addr_ok  out  1  fetch address accepted; iresp_data_ok  out  1  fetch data valid; iresp_data  out  32  instruction word.
REQ-006 dreq_valid  in  1  data request; dreq_addr  in  32; dreq_strobe  in  4  byte write enables, 0 = read; dreq_data  in  32  write data.
REQ-007 dresp_addr_ok  out  1; dresp_data_ok  out  1; dresp_data  out  32  read data.
REQ-008 mreq_valid  out  1; mreq_addr  out  32; mreq_strobe  out  4; mreq_data  out  32  shared memory port request.
REQ-009 mresp_addr_ok  in  1; mresp_data_ok  in  1; mresp_data  in  32  shared memory port response.

Function
REQ-010 The block SHALL arbitrate the single memory port between the fetch (I) and data (D) requesters, with one transaction outstanding at a time.
REQ-011 The FSM SHALL use states IDLE, ADDR and DATA, plus a 1-bit owner register (I/D).
REQ-012 IDLE: mreq_valid=0; if any req_valid is high, latch the winner into owner and go to ADDR next cycle; this is one cycle of arbitration latency.
REQ-013 Arbitration without MEM_ARB_RR_EN: D wins over I when both are valid.
REQ-014 ADDR: mreq_* SHALL mirror the owner's valid/addr/strobe/data (I: strobe=0, data=0); the owner's addr_ok SHALL equal mresp_addr_ok.
REQ-015 ADDR with mresp_addr_ok=1 SHALL go to DATA; if mresp_data_ok=1 in the same cycle, it SHALL complete per REQ-016 and go to IDLE.
REQ-016 DATA: on mresp_data_ok=1, the owner's data_ok=1 for exactly that cycle, its data = mresp_data, and next state = IDLE.
REQ-017 ADDR with owner valid=0 (request withdrawn) SHALL return to IDLE next cycle with no memory request issued.
REQ-018 The non-owner's addr_ok/data_ok SHALL be 0 in all states; in IDLE all addr_ok/data_ok SHALL be 0.
REQ-019 mresp_addr_ok/mresp_data_ok arriving in IDLE SHALL be ignored.
REQ-020 iresp_data and dresp_data SHALL be 0 whenever the corresponding data_ok is 0.
REQ-021 All outputs SHALL be combinational from state, owner and inputs; no output SHALL depend combinationally on a req_valid while in IDLE.

Reset
REQ-022 reset=1 SHALL force state=IDLE, owner=D and last-served=D (when MEM_ARB_RR_EN is defined) on the next edge.
REQ-023 While in IDLE after reset, every output SHALL be 0.
REQ-024 Reset during ADDR/DATA SHALL abandon the transaction; a late memory response SHALL NOT reach either requester.

Configuration
REQ-025 Macro MEM_ARB_RR_EN: when defined, the block SHALL add a last-served register updated on each completion (REQ-016), and a tie SHALL grant the requester not served last (the first tie after reset grants I).
REQ-026 When MEM_ARB_RR_EN is undefined, fixed D priority per REQ-013 applies and no last-served register exists.
REQ-027 A single valid requester SHALL win regardless of configuration.

Verification
REQ-028 Fetch read: ireq_valid=1, addr=0xbfc00000; memory addr_ok in cycle 2, data_ok in cycle 4 with 0x24080001 -> iresp_addr_ok in cycle 2, iresp_data_ok=1 with data 0x24080001 in cycle 4 only, and dresp_* = 0 throughout.
REQ-029 Simultaneous I@0xbfc00004 and D write @0x80000000 strobe 0xF data 0x12345678, without the macro -> D issued first with mreq_strobe=0xF, then I issued after D's data_ok plus 1 IDLE cycle.
REQ-030 Same stimulus with MEM_ARB_RR_EN defined, after reset -> I first, then D; repeated ties then alternate D, I, D.
REQ-031 Same-cycle addr_ok and data_ok in ADDR for a D read returning 0xdeadbeef -> dresp_addr_ok=1 and dresp_data_ok=1 in the same cycle, with IDLE on the next cycle.
REQ-032 reset asserted in DATA, then mresp_data_ok=1 one cycle after reset is released -> no data_ok on either side, and mreq_valid=0.
REQ-033 I granted, ireq_valid dropped in ADDR before addr_ok -> return to IDLE, and a pending D request is served next with its one-cycle latency.
